// File: rtl/c6288_test_pkg.sv
// Shared types and constants for the C6288 response-checking harness.
package c6288_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } chk_state_t;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] MISR_POLY  = 32'h0040_0007;
  localparam logic [7:0]  ERR_SAT    = 8'd255;
  localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

endpackage

// File: rtl/c6288_response_checker_misr32.sv
// 32-bit multiple-input signature register compacting the product stream.
module misr32
  import c6288_test_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sig
);

  // One Galois-style shift with feedback, then fold in the new word.
  function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0) ^ d;
  endfunction

  // Signature register: reseeded on clr, advanced on en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (clr) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_next(sig, din);
    end
  end

endmodule

// File: rtl/c6288_response_checker.sv
// Response checker for the C6288 16x16 multiplier: computes the golden
// product, aligns it to the DUT latency, counts mismatches and compacts
// every observed product into a MISR signature.
module c6288_response_checker
  import c6288_test_pkg::*;
#(
  parameter int          NUM_VEC = 8,
  parameter int          LAT     = 0,
  parameter logic [31:0] SEED    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [31:0] prod,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [15:0] first_err,
  output logic [31:0] signature
);

  localparam logic [15:0] LAST_IDX  = 16'(NUM_VEC - 1);
  localparam logic [2:0]  FILL_LAST = 3'(LAT - 1);

  chk_state_t  state, state_n;
  logic [15:0] vec_idx;
  logic [2:0]  fill_cnt;
  logic [31:0] golden;
  logic [31:0] exp_out;
  logic        arm, run, busy_d, done_d, pass_d;
  logic        mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_SAT) ? v : v + 8'd1;
  endfunction

  // Full-width unsigned product; zero-extending first keeps all 32 bits.
  assign golden   = {16'd0, op_a} * {16'd0, op_b};
  assign mismatch = (prod != exp_out);

  // ---- expected-value delay line: LAT stages, a plain wire when LAT=0 ----
  generate
    if (LAT > 0) begin : g_dly
      logic [31:0] exp_p [LAT];

      // Shift a fresh golden product in every FILL/RUN cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) exp_p[i] <= '0;
        end else if (state == FILL || state == RUN) begin
          exp_p[0] <= golden;
          for (int i = 1; i < LAT; i++) exp_p[i] <= exp_p[i-1];
        end
      end

      assign exp_out = exp_p[LAT-1];
    end else begin : g_nodly
      assign exp_out = golden;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; start is only honoured from IDLE and DONE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = (LAT > 0) ? FILL : RUN;
      FILL:       if (fill_cnt == FILL_LAST) state_n = RUN;
      RUN:        if (vec_idx == LAST_IDX) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  // Per-state control and next values of the registered status outputs.
  always_comb begin
    arm    = 1'b0;
    run    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    pass_d = 1'b0;
    unique case (state)
      IDLE: arm = start;
      FILL: busy_d = 1'b1;
      RUN: begin
        run    = 1'b1;
        busy_d = 1'b1;
      end
      DONE: begin
        arm    = start;
        done_d = 1'b1;
        pass_d = (err_cnt == 8'd0);
      end
      default: ;
    endcase
  end

  // Status outputs registered so none depends combinationally on DUT inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      pass <= pass_d;
    end
  end

  // Vector/fill counters and mismatch bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx   <= '0;
      fill_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= NO_ERR_IDX;
    end else if (arm) begin
      vec_idx   <= '0;
      fill_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= NO_ERR_IDX;
    end else begin
      if (state == FILL) fill_cnt <= fill_cnt + 3'd1;
      if (run) begin
        vec_idx <= vec_idx + 16'd1;
        if (mismatch) begin
          err_cnt <= sat_inc(err_cnt);
          if (first_err == NO_ERR_IDX) first_err <= vec_idx;
        end
      end
    end
  end

  misr32 #(
    .SEED(SEED)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (arm),
    .en  (run),
    .din (prod),
    .sig (signature)
  );

endmodule

// File: tb/tb_c6288_response_checker.sv
// Directed bench for c6288_response_checker. Four instances share the
// operand bus: LAT=0/NUM_VEC=8, LAT=2, LAT=1 (both fed a two-register
// delayed product) and a 300-vector instance for saturation.
module tb_c6288_response_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [4];
  logic [15:0] op_a, op_b;
  logic [31:0] prod_now, prod0, pipe1, pipe2;
  logic [31:0] zero_prod;
  logic        busy_v [4];
  logic        done_v [4];
  logic        pass_v [4];
  logic [7:0]  err_v  [4];
  logic [15:0] ferr_v [4];
  logic [31:0] sig_v  [4];
  logic [31:0] gold_sig, troj_sig;
  int          checks = 0;
  int          errors = 0;
  int          de;

  localparam logic [15:0] VA [8] = '{16'h0003, 16'h000F, 16'h1234, 16'hFFFF,
                                     16'h8000, 16'h00FF, 16'hABCD, 16'h7FFF};
  localparam logic [15:0] VB [8] = '{16'h0005, 16'h000F, 16'h0002, 16'hFFFF,
                                     16'h0002, 16'h0100, 16'h0003, 16'h8001};
  localparam logic [31:0] VP [8] = '{32'h0000_000F, 32'h0000_00E1, 32'h0000_2468, 32'hFFFE_0001,
                                     32'h0001_0000, 32'h0000_FF00, 32'h0002_0367, 32'h3FFF_FFFF};

  always #5 clk = ~clk;

  // Two-register model of a pipelined multiplier.
  always @(posedge clk) begin
    pipe1 <= prod_now;
    pipe2 <= pipe1;
  end

  c6288_response_checker #(.NUM_VEC(8), .LAT(0)) u_l0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op_a(op_a), .op_b(op_b), .prod(prod0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
    .first_err(ferr_v[0]), .signature(sig_v[0]));

  c6288_response_checker #(.NUM_VEC(8), .LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op_a(op_a), .op_b(op_b), .prod(pipe2),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
    .first_err(ferr_v[1]), .signature(sig_v[1]));

  c6288_response_checker #(.NUM_VEC(8), .LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .op_a(op_a), .op_b(op_b), .prod(pipe2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
    .first_err(ferr_v[2]), .signature(sig_v[2]));

  c6288_response_checker #(.NUM_VEC(300), .LAT(0)) u_sat (
    .clk(clk), .rst(rst), .start(start_v[3]), .op_a(op_a), .op_b(op_b), .prod(zero_prod),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_cnt(err_v[3]),
    .first_err(ferr_v[3]), .signature(sig_v[3]));

  function automatic logic [31:0] misr_model(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int inst);
    chk("rst_busy", 32'(busy_v[inst]), 32'd0);
    chk("rst_done", 32'(done_v[inst]), 32'd0);
    chk("rst_pass", 32'(pass_v[inst]), 32'd0);
    chk("rst_err_cnt", 32'(err_v[inst]), 32'd0);
    chk("rst_first_err", 32'(ferr_v[inst]), 32'h0000_FFFF);
    chk("rst_signature", sig_v[inst], 32'hFFFF_FFFF);
  endtask

  // Present vector k (or zeros when k is out of range); flip bit 0 of the
  // direct product on vector flip_idx.
  task automatic set_vec(input int k, input int flip_idx);
    if (k >= 0 && k < 8) begin
      op_a     = VA[k];
      op_b     = VB[k];
      prod_now = VP[k];
      prod0    = VP[k] ^ ((k == flip_idx) ? 32'h1 : 32'h0);
    end else begin
      op_a     = '0;
      op_b     = '0;
      prod_now = '0;
      prod0    = '0;
    end
  endtask

  // Start instance inst, stream the 8 vectors, return the edge done rose on.
  task automatic run8(input int inst, input int flip_idx, input bit poke_start,
                      input int exp_done, output int done_edge);
    done_edge = -1;
    @(negedge clk);
    start_v[inst] = 1'b1;
    set_vec(-1, flip_idx);
    @(posedge clk);
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      start_v[inst] = poke_start && (e == 4);
      set_vec(e - 1, flip_idx);
      @(posedge clk);
      #1;
      if (e == 2) chk("busy_in_run", 32'(busy_v[inst]), 32'd1);
      if (e == exp_done - 1) chk("pass_before_done", 32'(pass_v[inst]), 32'd0);
      if (done_v[inst] && done_edge < 0) done_edge = e;
    end
  endtask

  initial begin
    rst       = 1'b1;
    zero_prod = '0;
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    set_vec(-1, -1);

    gold_sig = 32'hFFFF_FFFF;
    troj_sig = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      gold_sig = misr_model(gold_sig, VP[k]);
      troj_sig = misr_model(troj_sig, VP[k] ^ ((k == 3) ? 32'h1 : 32'h0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    @(negedge clk);
    rst = 1'b0;

    // Golden pass, LAT=0
    run8(0, -1, 1'b0, 9, de);
    chk("gold_done_edge", 32'(de), 32'd9);
    chk("gold_pass", 32'(pass_v[0]), 32'd1);
    chk("gold_err_cnt", 32'(err_v[0]), 32'd0);
    chk("gold_first_err", 32'(ferr_v[0]), 32'h0000_FFFF);
    chk("gold_signature", sig_v[0], gold_sig);

    // Trojan flip on vector 3, started from DONE
    run8(0, 3, 1'b0, 9, de);
    chk("troj_done_edge", 32'(de), 32'd9);
    chk("troj_err_cnt", 32'(err_v[0]), 32'd1);
    chk("troj_first_err", 32'(ferr_v[0]), 32'd3);
    chk("troj_pass", 32'(pass_v[0]), 32'd0);
    chk("troj_signature", sig_v[0], troj_sig);
    chk("troj_sig_differs", 32'(sig_v[0] != gold_sig), 32'd1);

    // Restart from DONE with a start pulse during RUN that must be ignored
    run8(0, -1, 1'b1, 9, de);
    chk("rerun_done_edge", 32'(de), 32'd9);
    chk("rerun_pass", 32'(pass_v[0]), 32'd1);
    chk("rerun_err_cnt", 32'(err_v[0]), 32'd0);
    chk("rerun_first_err", 32'(ferr_v[0]), 32'h0000_FFFF);
    chk("rerun_signature", sig_v[0], gold_sig);

    // Reset during RUN vector 4
    @(negedge clk);
    start_v[0] = 1'b1;
    set_vec(-1, -1);
    @(posedge clk);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      set_vec(e - 1, -1);
      @(posedge clk);
    end
    #1;
    chk("mid_busy", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset(0);
    @(negedge clk);
    rst = 1'b0;
    run8(0, -1, 1'b0, 9, de);
    chk("post_rst_done_edge", 32'(de), 32'd9);
    chk("post_rst_pass", 32'(pass_v[0]), 32'd1);
    chk("post_rst_signature", sig_v[0], gold_sig);

    // Latency alignment, LAT=2 against a two-register DUT
    run8(1, -1, 1'b0, 11, de);
    chk("lat2_done_edge", 32'(de), 32'd11);
    chk("lat2_pass", 32'(pass_v[1]), 32'd1);
    chk("lat2_err_cnt", 32'(err_v[1]), 32'd0);
    chk("lat2_signature", sig_v[1], gold_sig);

    // Misaligned: LAT=1 against the same two-register DUT
    run8(2, -1, 1'b0, 10, de);
    chk("lat1_done_edge", 32'(de), 32'd10);
    chk("lat1_pass", 32'(pass_v[2]), 32'd0);
    chk("lat1_first_err", 32'(ferr_v[2]), 32'd0);

    // Saturation: 300 vectors of 1*1 against a stuck-at-zero product
    @(negedge clk);
    start_v[3] = 1'b1;
    op_a = 16'h0001;
    op_b = 16'h0001;
    @(posedge clk);
    de = -1;
    for (int e = 1; e <= 400 && de < 0; e++) begin
      @(negedge clk);
      start_v[3] = 1'b0;
      @(posedge clk);
      #1;
      if (done_v[3]) de = e;
    end
    chk("sat_done_edge", 32'(de), 32'd301);
    chk("sat_err_cnt", 32'(err_v[3]), 32'd255);
    chk("sat_first_err", 32'(ferr_v[3]), 32'd0);
    chk("sat_pass", 32'(pass_v[3]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c6288_response_checker.md
# c6288_response_checker

Response-side companion to the operand-vector ROM generator in the C6288 trojan-detection harness. Each cycle it samples the two 16-bit operands driven into the C6288 16×16 multiplier and the multiplier's 32-bit product. It computes the golden product internally, aligns it to the DUT latency, and counts mismatches. It also compacts every product into a 32-bit MISR signature and reports pass/fail once a programmed number of vectors has been checked.

## Interface
Parameters:
- `NUM_VEC`, default 8: number of compared vectors per run (1..65535).
- `LAT`, default 0: DUT latency in cycles from operand sample to product valid (0..7).
- `SEED`, default 32'hFFFF_FFFF: MISR initial value.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a run; accepted in IDLE and DONE only.
- `op_a`, in, 16: multiplier operand A (generator `out1`).
- `op_b`, in, 16: multiplier operand B (generator `out2`).
- `prod`, in, 32: DUT product.
- `busy`, out, 1: high in FILL and RUN.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: valid when `done`; 1 iff `err_cnt`==0.
- `err_cnt`, out, 8: mismatch count, saturating at 255.
- `first_err`, out, 16: index of the first mismatching vector; 16'hFFFF if none.
- `signature`, out, 32: MISR state.

## Operation
- States are IDLE, FILL, RUN and DONE. Reset enters IDLE.
- IDLE: on `start`, clear the counters, set `first_err`=FFFF and `signature`=SEED. Go to FILL if LAT>0, otherwise to RUN.
- FILL: for LAT cycles, push `op_a*op_b` into the expected delay line. No compare, no MISR update. Then go to RUN.
- RUN: every cycle:
  - Push the new expected value.
  - Compare `prod` against the delay-line output (the LAT-cycles-old expected value; the current `op_a*op_b` when LAT=0).
  - Update the MISR with `prod`.
  - Increment `vec_idx`.
  - After the compare at `vec_idx`==NUM_VEC-1, go to DONE.
- On mismatch: `err_cnt` increments unless it is already 255. If `first_err`==FFFF, `first_err` takes the current `vec_idx`.
- MISR update: sig ← {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ prod, with POLY=32'h0040_0007 (x^32+x^22+x^2+x+1).
- Golden product is a full unsigned 32-bit product of two 16-bit operands; no truncation.
- DONE: all outputs are held. `start` re-arms exactly as it does from IDLE.
- `start` in FILL or RUN is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err`=16'hFFFF, `signature`=SEED, state=IDLE. The delay line and `vec_idx` are also cleared.
- The `start` sample edge is edge 0. The first RUN compare happens on edge LAT+1. `done` rises on edge LAT+NUM_VEC+1.
- `pass` is registered together with the DONE entry, so it never glitches and reads 0 before `done`.
- All outputs are registered; the DUT inputs have no combinational path to any output.
- Asserting `rst` mid-run aborts immediately to the reset values. Nothing partial is reported.
- If a mismatch occurs on the same edge that `err_cnt` reaches 255, the count stays 255 and `first_err` is unaffected.
- `vec_idx` is 16-bit and never wraps within a legal NUM_VEC.

## Structure
- Shared package `c6288_test_pkg` holds:
  - the state enum type `chk_state_t`;
  - `MISR_POLY` = 32'h0040_0007;
  - `ERR_SAT` = 8'd255;
  - `NO_ERR_IDX` = 16'hFFFF.
- Sub-module `misr32` holds the signature register. Its ports are `clk`, `rst`, `clr`, `en`, `din[31:0]` and `sig[31:0]`, and it uses the `SEED` parameter.
- The expected delay line is an LAT-deep shift register inside the top module. For LAT=0 it degenerates to a wire.

## Test plan
- Golden pass, LAT=0, NUM_VEC=8, generator vectors (including 000F·000F=0000_00E1 and FFFF·FFFF=FFFE_0001), DUT correct → `done` on edge 9, `pass`=1, `err_cnt`=0, `first_err`=FFFF, and `signature` equal to the bench reference model.
- Trojan flip, same setup with bit 0 of `prod` inverted on vector 3 (FFFE_0000 instead of FFFE_0001) → `err_cnt`=1, `first_err`=3, `pass`=0. `signature` differs from the golden run.
- Latency alignment, LAT=2 with `prod` delayed by two registers in the bench → `done` on edge 11 and `pass`=1. With the same DUT but LAT=1 → `pass`=0 and `first_err`=0.
- Saturation, NUM_VEC=300, with `prod` forced to 0 and operands 0001·0001 → `err_cnt`=255, `first_err`=0.
- Reset mid-run: assert `rst` at RUN vector 4 → all outputs return to their reset values within the same cycle. A new `start` completes a clean 8-vector pass.
- Restart/ignore: `start` pulsed during RUN has no effect. `start` in DONE clears the results and reruns, giving an identical signature.
